// File: rtl/med_reminder_sched.sv
// med_reminder_sched: multi-channel medication reminder scheduler with due alarm, grace period and missed-dose count.
// Define MEDREM_SNOOZE_EN to add the per-channel snooze input and its ALERT->COUNT reload.
module med_reminder_sched #(
   parameter int CHANNELS = 4,
   parameter int INTERVAL_W = 16,
   parameter int TICK_DIV = 1000,
   parameter int GRACE = 8,
   parameter int MISS_W = 4,
`ifdef MEDREM_SNOOZE_EN
   parameter int SNOOZE_TICKS = 4,
`endif
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  cfg_we,
   input  logic [CW-1:0]         cfg_ch,
   input  logic [INTERVAL_W-1:0] cfg_interval,
   input  logic [CHANNELS-1:0]   ack,
`ifdef MEDREM_SNOOZE_EN
   input  logic [CHANNELS-1:0]   snooze,
`endif
   input  logic [CW-1:0]         miss_sel,
   output logic [CHANNELS-1:0]   alarm,
   output logic [CHANNELS-1:0]   missed,
   output logic [CW-1:0]         active_ch,
   output logic [MISS_W-1:0]     miss_count,
   output logic                  buzz,
   output logic                  tick
);
   localparam int PW = $clog2(TICK_DIV);
   localparam int GW = $clog2(GRACE + 1);
   typedef enum logic [1:0] {IDLE, COUNT, ALERT, MISSED} state_t;
   state_t                r_state    [CHANNELS];
   logic [INTERVAL_W-1:0] r_interval [CHANNELS];
   logic [INTERVAL_W-1:0] r_count    [CHANNELS];
   logic [GW-1:0]         r_grace    [CHANNELS];
   logic [MISS_W-1:0]     r_miss     [CHANNELS];
   logic [PW-1:0]         r_pre;
   logic                  r_buzz;
   logic                  w_tick;
   logic [CHANNELS-1:0]   w_alert;

   assign w_tick = enable && (r_pre == PW'(TICK_DIV - 1));
   assign tick = w_tick;

   always_ff @(posedge clk or posedge rst)
      if (rst) r_pre <= '0;
      else if (enable) r_pre <= w_tick ? '0 : r_pre + 1'b1;

   // cfg_we beats ack beats snooze beats tick within a channel
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_state[i] <= IDLE;
            r_interval[i] <= '0;
            r_count[i] <= '0;
            r_grace[i] <= '0;
            r_miss[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++)
            if (cfg_we && cfg_ch == CW'(i)) begin
               r_interval[i] <= cfg_interval;
               r_count[i] <= cfg_interval;
               r_state[i] <= (cfg_interval == '0) ? IDLE : COUNT;
            end else case (r_state[i])
               COUNT: if (w_tick) begin
                  r_count[i] <= r_count[i] - 1'b1;
                  if (r_count[i] == INTERVAL_W'(1)) begin
                     r_state[i] <= ALERT;
                     r_grace[i] <= GW'(GRACE);
                  end
               end
               ALERT: if (ack[i]) begin
                  r_state[i] <= COUNT;
                  r_count[i] <= r_interval[i];
               end
`ifdef MEDREM_SNOOZE_EN
               else if (snooze[i]) begin
                  r_state[i] <= COUNT;
                  r_count[i] <= INTERVAL_W'(SNOOZE_TICKS);
               end
`endif
               else if (w_tick) begin
                  r_grace[i] <= r_grace[i] - 1'b1;
                  if (r_grace[i] == GW'(1)) begin
                     r_state[i] <= MISSED;
                     if (r_miss[i] != '1) r_miss[i] <= r_miss[i] + 1'b1;
                  end
               end
               MISSED: if (ack[i]) begin
                  r_state[i] <= COUNT;
                  r_count[i] <= r_interval[i];
               end
               default: ;
            endcase
      end

   always_comb begin
      alarm = '0;
      missed = '0;
      w_alert = '0;
      active_ch = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         w_alert[i] = r_state[i] == ALERT;
         missed[i] = r_state[i] == MISSED;
         alarm[i] = w_alert[i] || missed[i];
         if (alarm[i]) active_ch = CW'(i);
      end
   end

   assign miss_count = (int'(miss_sel) < CHANNELS) ? r_miss[miss_sel] : '0;

   // toggle flop only runs while something is alerting, so it restarts from 0
   always_ff @(posedge clk or posedge rst)
      if (rst) r_buzz <= 1'b0;
      else r_buzz <= (|w_alert) ? r_buzz ^ w_tick : 1'b0;

   assign buzz = (|missed) || ((|w_alert) && r_buzz);
endmodule

// File: tb/tb_med_reminder_sched.sv
// tb_med_reminder_sched: scoreboard bench for med_reminder_sched with TICK_DIV=4, CHANNELS=4, GRACE=2, MISS_W=2.
module tb_med_reminder_sched;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b1;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_ch = '0;
   logic [7:0] cfg_interval = '0;
   logic [3:0] ack = '0;
`ifdef MEDREM_SNOOZE_EN
   logic [3:0] snooze = '0;
`endif
   logic [1:0] miss_sel = '0;
   logic [3:0] alarm, missed;
   logic [1:0] active_ch, miss_count;
   logic       buzz, tick;
   int         n_vec = 0, n_bad = 0, nt;

   typedef struct packed {
      logic [3:0] al;
      logic [3:0] mi;
      logic [1:0] ac;
      logic       bz;
      logic [1:0] mc;
   } exp_t;
   exp_t  sbq[$];
   string tq[$];

   med_reminder_sched #(.CHANNELS(4), .INTERVAL_W(8), .TICK_DIV(4), .GRACE(2), .MISS_W(2)
`ifdef MEDREM_SNOOZE_EN
      , .SNOOZE_TICKS(4)
`endif
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_interval(cfg_interval), .ack(ack),
`ifdef MEDREM_SNOOZE_EN
      .snooze(snooze),
`endif
      .miss_sel(miss_sel), .alarm(alarm), .missed(missed), .active_ch(active_ch),
      .miss_count(miss_count), .buzz(buzz), .tick(tick));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [3:0] al, input logic [3:0] mi,
                       input logic [1:0] ac, input logic bz, input logic [1:0] mc);
      sbq.push_back('{al, mi, ac, bz, mc});
      tq.push_back(tag);
   endtask

   task automatic pop_check();
      exp_t  e = sbq.pop_front();
      string t = tq.pop_front();
      chk({t, ".alarm"}, 32'(alarm), 32'(e.al));
      chk({t, ".missed"}, 32'(missed), 32'(e.mi));
      chk({t, ".active_ch"}, 32'(active_ch), 32'(e.ac));
      chk({t, ".buzz"}, 32'(buzz), 32'(e.bz));
      chk({t, ".miss_count"}, 32'(miss_count), 32'(e.mc));
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // advance until the n-th tick edge has been applied
   task automatic wait_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         int g = 0;
         while (!tick && g < 10) begin
            step(1);
            g++;
         end
         if (!tick) chk("tick_timeout", 32'(tick), 32'd1);
         step(1);
      end
   endtask

   task automatic write(input logic [1:0] ch, input logic [7:0] iv);
      cfg_we = 1'b1;
      cfg_ch = ch;
      cfg_interval = iv;
      step(1);
      cfg_we = 1'b0;
   endtask

   task automatic pulse_ack(input logic [3:0] a);
      ack = a;
      step(1);
      ack = '0;
   endtask

   initial begin
      step(3);
      push("reset", 4'h0, 4'h0, 2'd0, 1'b0, 2'd0);
      pop_check();
      chk("reset.tick", 32'(tick), 32'd0);
      rst = 1'b0;
      nt = 0;
      for (int c = 0; c < 40; c++) begin
         nt += int'(tick);
         step(1);
      end
      chk("idle.ticks", 32'(nt), 32'd10);
      push("idle", 4'h0, 4'h0, 2'd0, 1'b0, 2'd0);
      pop_check();

      miss_sel = 2'd1;
      write(2'd1, 8'd3);
      push("ch1.two_ticks", 4'h0, 4'h0, 2'd0, 1'b0, 2'd0);
      wait_ticks(2);
      pop_check();
      push("ch1.due", 4'h2, 4'h0, 2'd1, 1'b0, 2'd0);
      wait_ticks(1);
      pop_check();
      push("ch1.buzz_toggle", 4'h2, 4'h0, 2'd1, 1'b1, 2'd0);
      wait_ticks(1);
      pop_check();
      push("ch1.ack", 4'h0, 4'h0, 2'd0, 1'b0, 2'd0);
      pulse_ack(4'h2);
      pop_check();
      push("ch1.reload_2", 4'h0, 4'h0, 2'd0, 1'b0, 2'd0);
      wait_ticks(2);
      pop_check();
      push("ch1.redue", 4'h2, 4'h0, 2'd1, 1'b0, 2'd0);
      wait_ticks(1);
      pop_check();
      push("ch1.grace1", 4'h2, 4'h0, 2'd1, 1'b1, 2'd0);
      wait_ticks(1);
      pop_check();
      push("ch1.missed1", 4'h2, 4'h2, 2'd1, 1'b1, 2'd1);
      wait_ticks(1);
      pop_check();
      for (int k = 2; k <= 4; k++) begin
         pulse_ack(4'h2);
         push($sformatf("ch1.redue%0d", k), 4'h2, 4'h0, 2'd1, 1'b0, 2'(k - 1 > 3 ? 3 : k - 1));
         wait_ticks(3);
         pop_check();
         push($sformatf("ch1.missed%0d", k), 4'h2, 4'h2, 2'd1, 1'b1, 2'(k > 3 ? 3 : k));
         wait_ticks(2);
         pop_check();
      end
      push("ch1.missed_holds", 4'h2, 4'h2, 2'd1, 1'b1, 2'd3);
      wait_ticks(1);
      pop_check();

      push("ch1.disable_with_ack", 4'h0, 4'h0, 2'd0, 1'b0, 2'd3);
      ack = 4'h2;
      write(2'd1, 8'd0);
      ack = '0;
      pop_check();

      nt = 0;
      while (!tick && nt < 10) begin
         step(1);
         nt++;
      end
      chk("sync.tick", 32'(tick), 32'd1);
      write(2'd0, 8'd2);
      write(2'd2, 8'd2);
      miss_sel = 2'd0;
      push("ch0ch2.due", 4'h5, 4'h0, 2'd0, 1'b0, 2'd0);
      wait_ticks(2);
      pop_check();
      push("ch0.ack", 4'h4, 4'h0, 2'd2, 1'b0, 2'd0);
      pulse_ack(4'h1);
      pop_check();

      enable = 1'b0;
      nt = 0;
      for (int c = 0; c < 20; c++) begin
         nt += int'(tick);
         step(1);
      end
      chk("frozen.ticks", 32'(nt), 32'd0);
      push("frozen", 4'h4, 4'h0, 2'd2, 1'b0, 2'd0);
      pop_check();
      enable = 1'b1;
      miss_sel = 2'd2;
      push("resume", 4'h5, 4'h4, 2'd0, 1'b1, 2'd1);
      wait_ticks(2);
      pop_check();

      rst = 1'b1;
      #1;
      push("async_rst", 4'h0, 4'h0, 2'd0, 1'b0, 2'd0);
      pop_check();
      step(1);
      rst = 1'b0;

      miss_sel = 2'd3;
      write(2'd3, 8'd1);
      push("ch3.due", 4'h8, 4'h0, 2'd3, 1'b0, 2'd0);
      wait_ticks(1);
      pop_check();
`ifdef MEDREM_SNOOZE_EN
      push("ch3.snooze", 4'h0, 4'h0, 2'd0, 1'b0, 2'd0);
      snooze = 4'h8;
      step(1);
      snooze = '0;
      pop_check();
      push("ch3.snoozed_3", 4'h0, 4'h0, 2'd0, 1'b0, 2'd0);
      wait_ticks(3);
      pop_check();
      push("ch3.snooze_due", 4'h8, 4'h0, 2'd3, 1'b0, 2'd0);
      wait_ticks(1);
      pop_check();
`endif
      push("ch3.ack", 4'h0, 4'h0, 2'd0, 1'b0, 2'd0);
      pulse_ack(4'h8);
      pop_check();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/med_reminder_sched.md
# med_reminder_sched

Multi-channel medication reminder scheduler, the parametrised successor of the single-schedule reminder core inside the TinyTapeout user-project wrapper. It holds CHANNELS independent dose schedules, each with a programmable interval counted in prescaled ticks. Each channel raises an alarm when its dose is due, accepts a per-channel acknowledge, and escalates to a saturating missed-dose count after a grace period. It sits between the wrapper's input decode (config and ack buttons) and its output pins (alarm LEDs, buzzer).

## Interface
- CHANNELS, 4: number of independent schedules (1..8).
- INTERVAL_W, 16: width of interval and countdown registers, in ticks.
- TICK_DIV, 1000: clk cycles per tick (≥2).
- GRACE, 8: ticks in ALERT before a dose is declared missed (≥1).
- MISS_W, 4: width of per-channel saturating missed counter.
- SNOOZE_TICKS, 4: reload value on snooze (only with MEDREM_SNOOZE_EN).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  time-base run; low freezes prescaler and all countdowns.
- cfg_we  in  1  one-cycle write strobe.
- cfg_ch  in  $clog2(CHANNELS) (min 1)  channel selected for write.
- cfg_interval  in  INTERVAL_W  new interval; 0 disables the channel.
- ack  in  CHANNELS  per-channel acknowledge, level sampled each cycle.
- snooze  in  CHANNELS  per-channel snooze (present only with MEDREM_SNOOZE_EN).
- miss_sel  in  $clog2(CHANNELS) (min 1)  read select for miss_count.
- alarm  out  CHANNELS  channel in ALERT or MISSED.
- missed  out  CHANNELS  channel in MISSED.
- active_ch  out  $clog2(CHANNELS) (min 1)  lowest-index alarming channel; 0 if none.
- miss_count  out  MISS_W  missed counter of channel miss_sel (combinational read).
- buzz  out  1  buzzer drive.
- tick  out  1  one-cycle time-base pulse (debug).

## Operation
- Prescaler counts 0..TICK_DIV-1 while enable is high; tick=1 on the cycle where count==TICK_DIV-1, then wraps to 0. When enable is low, the count holds and tick=0.
- Per-channel FSM: IDLE, COUNT, ALERT, MISSED.
- IDLE: no countdown. cfg_we to this channel with a nonzero interval → COUNT, countdown=interval.
- COUNT: on tick, decrement. On tick with countdown==1 → ALERT, grace=GRACE. ack is ignored.
- ALERT: ack → COUNT, countdown reloads the stored interval. On tick, decrement grace. On tick with grace==1 → MISSED and miss_count+1, saturating at 2^MISS_W-1.
- MISSED: alarm and missed high. ack → COUNT with reload. Ticks have no effect.
- cfg_we with interval 0 → IDLE from any state; the stored interval clears. cfg_we with nonzero interval → COUNT with the new value, from any state. miss_count is never cleared by cfg_we.
- Priority per channel, same cycle: cfg_we > ack > snooze > tick.
- active_ch is a priority encode of alarm, lowest index first.
- buzz: 1 if any channel is MISSED. Otherwise a toggle flop (flipped on each tick while any channel is in ALERT) when any channel is in ALERT. Otherwise 0, and the flop clears.

## Timing
- Reset values: all FSMs IDLE; intervals, countdowns, grace, miss counters and prescaler 0. alarm, missed, active_ch, buzz, tick and miss_count all 0.
- State transitions are registered. alarm, missed, active_ch and buzz are decoded from registered state, so they change the cycle after the causing tick, ack or cfg_we edge.
- Due latency: a write of interval N reaches ALERT on the N-th subsequent tick.
- ack held multiple cycles is harmless: the first cycle moves to COUNT, and later cycles are ignored in COUNT.
- rst asserted mid-operation clears everything immediately, including miss counters.

## Configuration
- MEDREM_SNOOZE_EN defined: the snooze port exists. snooze in ALERT → COUNT with countdown=SNOOZE_TICKS, and no miss is recorded. snooze is ignored in other states.
- MEDREM_SNOOZE_EN undefined: there is no snooze port and no snooze logic. ALERT exits only by ack, cfg_we, or grace expiry.

## Test plan
Parameters: TICK_DIV=4, CHANNELS=4, GRACE=2, MISS_W=2.
- Reset, then idle 40 cycles → all outputs 0 and tick every 4th cycle.
- Write ch1 interval 3 → alarm[1]=1 the cycle after the 3rd tick; active_ch=1; buzz toggles on each tick.
- ch1 in ALERT, ack[1] pulse → alarm[1]=0 next cycle; alarm reasserts 3 ticks later.
- No ack for 2 ticks in ALERT → missed[1]=1, buzz=1, miss_count (miss_sel=1)=1. Repeat 4 times → saturates at 3.
- ch0 and ch2 due on the same tick → alarm=4'b0101, active_ch=0. Ack ch0 → active_ch=2.
- With MEDREM_SNOOZE_EN: snooze in ALERT → alarm clears and returns after 4 ticks, miss_count unchanged. Also: cfg_we interval 0 with simultaneous ack → IDLE. Also: enable low for 20 cycles → no state change.
